// File: rtl/switch_conditioner.sv
// Per-channel switch conditioner: two-flop synchronizer, tick-paced debounce
// with an independent counter/FSM per bit, and registered edge pulses.
module switch_conditioner #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    state_t        state_q [WIDTH];
    state_t        state_d [WIDTH];
    logic [CW-1:0] cnt_q   [WIDTH];
    logic [CW-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             any_d;

    // Metastability synchronizer for the raw board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
            sw_out     <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            any_change <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sw_out     <= out_d;
            sw_rise    <= rise_d;
            sw_fall    <= fall_d;
            any_change <= any_d;
        end
    end

    // Next-state: the first mismatching edge already counts a tick, so a clean
    // step is accepted STABLE_CYCLES edges after it leaves the synchronizer.
    always_comb begin
        logic [CW-1:0] base;
        base   = '0;
        out_d  = sw_out;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            base       = (state_q[i] == STABLE) ? '0 : cnt_q[i];
            if (s2[i] == sw_out[i]) begin
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else if (!tick) begin
                state_d[i] = PENDING;
                cnt_d[i]   = base;
            end else if (base == LAST) begin
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
                out_d[i]   = s2[i];
                rise_d[i]  = s2[i];
                fall_d[i]  = ~s2[i];
            end else begin
                state_d[i] = PENDING;
                cnt_d[i]   = base + CW'(1);
            end
        end
        any_d = |(rise_d | fall_d);
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed self-checking bench for switch_conditioner (WIDTH=8, STABLE_CYCLES=4).
module tb_switch_conditioner;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SC    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             any_change;

    int n_chk  = 0;
    int n_pass = 0;

    switch_conditioner #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // advance one rising edge and settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rise"}, 32'(sw_rise), 32'h0);
        chk({tag, "_fall"}, 32'(sw_fall), 32'h0);
        chk({tag, "_any"},  32'(any_change), 32'h0);
    endtask

    // clean step with tick=1: accepted on edge SC+2, pulses visible that cycle only
    task automatic settle(input string tag, input logic [7:0] v, input logic [7:0] prev);
        sw_in = v;
        for (int e = 1; e <= SC + 1; e++) cyc();
        chk({tag, "_pre_out"}, 32'(sw_out), 32'(prev));
        chk_quiet({tag, "_pre"});
        cyc();
        chk({tag, "_out"},  32'(sw_out), 32'(v));
        chk({tag, "_rise"}, 32'(sw_rise), 32'(v & ~prev));
        chk({tag, "_fall"}, 32'(sw_fall), 32'(prev & ~v));
        chk({tag, "_any"},  32'(any_change), 32'(v != prev));
        cyc();
        chk({tag, "_hold_out"}, 32'(sw_out), 32'(v));
        chk_quiet({tag, "_post"});
    endtask

    initial begin
        rst   = 1'b1;
        tick  = 1'b1;
        sw_in = 8'h00;
        cyc();
        cyc();
        chk("rst_out", 32'(sw_out), 32'h0);
        chk_quiet("rst");
        rst = 1'b0;
        cyc();

        // basic rise then fall on bit 0
        settle("step01", 8'h01, 8'h00);
        settle("step00", 8'h00, 8'h01);

        // 3-cycle glitch must never be accepted
        sw_in = 8'h01;
        for (int e = 0; e < 3; e++) cyc();
        sw_in = 8'h00;
        for (int e = 0; e < 6; e++) begin
            cyc();
            chk("glitch_out", 32'(sw_out), 32'h0);
            chk("glitch_any", 32'(any_change), 32'h0);
        end
        // a stale count would shorten this latency
        settle("after_glitch", 8'h01, 8'h00);
        settle("back0", 8'h00, 8'h01);

        // simultaneous rise and fall on different bits
        settle("to02", 8'h02, 8'h00);
        settle("02to04", 8'h04, 8'h02);
        settle("04to00", 8'h00, 8'h04);

        // alternating tick: ticks counted on edges 3,5,7,9 -> accept on edge 9
        sw_in = 8'h80;
        for (int e = 1; e <= 8; e++) begin
            tick = (e % 2 == 1);
            cyc();
        end
        chk("tick_pre_out", 32'(sw_out), 32'h0);
        chk("tick_pre_any", 32'(any_change), 32'h0);
        tick = 1'b1;
        cyc();
        chk("tick_out",  32'(sw_out), 32'h80);
        chk("tick_rise", 32'(sw_rise), 32'h80);
        chk("tick_any",  32'(any_change), 32'h1);
        tick = 1'b0;
        cyc();
        chk("tick_post_rise", 32'(sw_rise), 32'h0);
        tick = 1'b1;

        // reset mid-pending aborts the transition without pulses
        sw_in = 8'hFF;
        for (int e = 1; e <= 4; e++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_out", 32'(sw_out), 32'h0);
        chk_quiet("mid_rst");
        for (int e = 1; e <= 5; e++) begin
            cyc();
            chk("post_rst_out", 32'(sw_out), 32'h0);
            chk("post_rst_any", 32'(any_change), 32'h0);
        end
        cyc();
        chk("post_rst_acc_out",  32'(sw_out), 32'hFF);
        chk("post_rst_acc_rise", 32'(sw_rise), 32'hFF);
        chk("post_rst_acc_fall", 32'(sw_fall), 32'h0);
        chk("post_rst_acc_any",  32'(any_change), 32'h1);
        cyc();
        chk_quiet("post_rst_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter WIDTH, default 8: number of switch channels conditioned.
REQ-002 Parameter STABLE_CYCLES, default 500000: number of counted ticks a new level must persist before acceptance; legal range 1..2^24-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tick  input  1  count enable; tie to 1 for per-cycle counting.
REQ-006 sw_in  input  WIDTH  raw asynchronous board switches.
REQ-007 sw_out  output  WIDTH  debounced, synchronized switch levels; drives the downstream sw bus.
REQ-008 sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1.
REQ-009 sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0.
REQ-010 any_change  output  1  OR of all sw_rise and sw_fall bits, same cycle.

Function
REQ-011 The block SHALL pass each sw_in bit through a two-flop synchronizer (s1 <= sw_in, s2 <= s1) before any other use.
REQ-012 Each bit SHALL own an independent counter of ceil(log2(STABLE_CYCLES+1)) bits and a two-state FSM: STABLE (s2 == sw_out) and PENDING (s2 != sw_out).
REQ-013 In STABLE, the counter SHALL be 0; entry to PENDING occurs on the first edge where s2 != sw_out.
REQ-014 In PENDING with tick=1 and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 In PENDING with tick=0, the counter SHALL hold.
REQ-016 In PENDING with tick=1 and counter == STABLE_CYCLES-1, on that edge sw_out[i] SHALL take s2[i], the counter SHALL clear, and the FSM SHALL return to STABLE.
REQ-017 Whenever s2[i] == sw_out[i] (glitch ended), the counter SHALL clear to 0 on that edge regardless of tick; sw_out[i] SHALL not change.
REQ-018 sw_rise[i]/sw_fall[i] SHALL be registered and asserted for exactly the one cycle following the edge that updated sw_out[i], matching the direction; otherwise 0.
REQ-019 With tick held 1 and a clean step, sw_out SHALL change on the (STABLE_CYCLES+2)th rising edge counting the first edge that samples the new sw_in level as edge 1.
REQ-020 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL produce simultaneous pulses, any_change asserted once for that cycle.
REQ-021 The counter SHALL never exceed STABLE_CYCLES-1; no wrap-around is permitted.
REQ-022 sw_rise and sw_fall SHALL never both be 1 for the same bit in the same cycle.

Reset
REQ-023 While rst=1 at a clock edge: s1, s2, sw_out, sw_rise, sw_fall, any_change, all counters SHALL become 0 and all FSMs STABLE.
REQ-024 Reset asserted mid-PENDING SHALL discard the partial count; no pulse SHALL be emitted for the aborted transition.
REQ-025 After rst deasserts, a switch already high SHALL be accepted per REQ-019 and SHALL produce a sw_rise pulse.

Verification (STABLE_CYCLES=4, WIDTH=8, tick=1 unless stated)
REQ-026 sw_in 0x00->0x01 held -> sw_out becomes 0x01 on edge 6 after the step is first sampled; sw_rise=0x01 and any_change=1 for exactly the next cycle.
REQ-027 sw_in bit 0 high for 3 cycles then low -> sw_out stays 0x00, no pulses; counter returns to 0.
REQ-028 sw_out=0x02, sw_in 0x02->0x04 in one cycle -> after latency sw_out=0x04, sw_rise=0x04 and sw_fall=0x02 in the same cycle, any_change=1.
REQ-029 Step sw_in 0x00->0x80 with tick alternating 1,0 -> acceptance delayed until 4 ticks counted; tick=0 cycles hold the counter.
REQ-030 sw_in=0xFF, rst pulsed one cycle after 2 counted ticks -> all outputs 0 after reset, no pulses; sw_out=0xFF on edge 6 after rst deasserts with sw_rise=0xFF.
